// File: rtl/soc_result_sink.sv
// Result sink for the SoC datapath: captures {mixed,y1,y0} triples into a small FIFO,
// sums drained entries into a checksum, and latches IRQ rising edges as maskable pending bits.
module soc_result_sink #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_en,
    input  logic [7:0]               y0,
    input  logic [7:0]               y1,
    input  logic [7:0]               mixed,
    input  logic [3:0]               irq_in,
    input  logic [3:0]               irq_mask,
    input  logic [3:0]               irq_clr,
    input  logic                     ovf_clr,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [23:0]              rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CW-1:0]            checksum,
    output logic [3:0]               irq_pending,
    output logic                     irq_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] checksum_q, checksum_d;
    logic [3:0]    irq_prev_q;
    logic [3:0]    irq_pending_q, irq_pending_d;
    logic [3:0]    irq_edge;
    logic          push, pop, drop;

    // Read handshake: a transfer (pop) happens on a rising edge where rd_valid && rd_ready;
    // rd_valid never depends on rd_ready, and rd_data holds the head while rd_valid is high.
    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 24'h0;

    assign pop  = rd_valid & rd_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push = cap_en & ((count_q != FULL_CNT) | pop);
    assign drop = cap_en & ~push;

    assign irq_edge = irq_in & ~irq_prev_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        checksum_d    = checksum_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            checksum_d = checksum_q + CW'(rd_data[7:0]) + CW'(rd_data[15:8])
                         + CW'(rd_data[23:16]);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as the clear keeps the flag set.
        overflow_d    = drop | (overflow_q & ~ovf_clr);
        irq_pending_d = irq_edge | (irq_pending_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            checksum_q    <= '0;
            irq_prev_q    <= '0;
            irq_pending_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            checksum_q    <= checksum_d;
            irq_prev_q    <= irq_in;
            irq_pending_q <= irq_pending_d;
        end
    end

    // Storage carries no reset; only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {mixed, y1, y0};
    end

    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign checksum    = checksum_q;
    assign irq_pending = irq_pending_q;
    assign irq_out     = |(irq_pending_q & irq_mask);

endmodule

// File: tb/tb_soc_result_sink.sv
// Directed bench for soc_result_sink: FIFO order/overflow, checksum wrap, IRQ pending bits,
// and asynchronous reset in the middle of a drain.
module tb_soc_result_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cap_en;
    logic [7:0]  y0, y1, mixed;
    logic [3:0]  irq_in, irq_mask, irq_clr;
    logic        ovf_clr, rd_ready;
    logic        rd_valid, rd_valid8;
    logic [23:0] rd_data, rd_data8;
    logic [2:0]  fifo_count, fifo_count8;
    logic        overflow, overflow8;
    logic [15:0] checksum;
    logic [7:0]  checksum8;
    logic [3:0]  irq_pending, irq_pending8;
    logic        irq_out, irq_out8;

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_e;

    soc_result_sink #(.DEPTH(4), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .y0(y0), .y1(y1), .mixed(mixed),
        .irq_in(irq_in), .irq_mask(irq_mask), .irq_clr(irq_clr), .ovf_clr(ovf_clr),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_count(fifo_count), .overflow(overflow), .checksum(checksum),
        .irq_pending(irq_pending), .irq_out(irq_out)
    );

    // Second instance with an 8-bit checksum, driven by the same stimulus.
    soc_result_sink #(.DEPTH(4), .CW(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .y0(y0), .y1(y1), .mixed(mixed),
        .irq_in(irq_in), .irq_mask(irq_mask), .irq_clr(irq_clr), .ovf_clr(ovf_clr),
        .rd_ready(rd_ready), .rd_valid(rd_valid8), .rd_data(rd_data8),
        .fifo_count(fifo_count8), .overflow(overflow8), .checksum(checksum8),
        .irq_pending(irq_pending8), .irq_out(irq_out8)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cap_en = 1'b0; y0 = 8'h0; y1 = 8'h0; mixed = 8'h0;
        irq_in = 4'h0; irq_mask = 4'h0; irq_clr = 4'h0;
        ovf_clr = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Drive one capture cycle and record the entry the FIFO is expected to keep.
    task automatic capture(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                           input bit expect_kept);
        cap_en = 1'b1; y0 = a; y1 = b; mixed = m;
        if (expect_kept) exp_q.push_back({m, b, a});
        tick();
        cap_en = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        rd_ready = 1'b1;
        while (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check({tag, "_valid"}, {31'h0, rd_valid}, 32'h1);
            check({tag, "_data"}, {8'h0, rd_data}, {8'h0, exp_e});
            tick();
        end
        rd_ready = 1'b0;
        check({tag, "_empty_valid"}, {31'h0, rd_valid}, 32'h0);
        check({tag, "_empty_data"}, {8'h0, rd_data}, 32'h0);
        check({tag, "_empty_count"}, {29'h0, fifo_count}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_valid", {31'h0, rd_valid}, 32'h0);
        check("rst_data", {8'h0, rd_data}, 32'h0);
        check("rst_count", {29'h0, fifo_count}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_cks", {16'h0, checksum}, 32'h0);
        check("rst_pend", {28'h0, irq_pending}, 32'h0);
        check("rst_irq", {31'h0, irq_out}, 32'h0);
        do_reset();

        // Single capture becomes visible the next cycle
        capture(8'h12, 8'h34, 8'h26, 1'b1);
        check("one_valid", {31'h0, rd_valid}, 32'h1);
        check("one_data", {8'h0, rd_data}, 32'h263412);
        check("one_count", {29'h0, fifo_count}, 32'h1);
        check("one_ovf", {31'h0, overflow}, 32'h0);
        drain_check("one_drain");
        check("one_cks", {16'h0, checksum}, 32'h006C);

        // Five captures into a depth-4 FIFO
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            capture(8'(i), 8'(8'h10 + i), 8'(i) ^ 8'(8'h10 + i), i <= 4);
            if (i == 4) begin
                check("fill4_count", {29'h0, fifo_count}, 32'h4);
                check("fill4_ovf", {31'h0, overflow}, 32'h0);
            end
        end
        check("fill5_count", {29'h0, fifo_count}, 32'h4);
        check("fill5_ovf", {31'h0, overflow}, 32'h1);
        // Drop while clearing: the drop wins
        ovf_clr = 1'b1;
        capture(8'hEE, 8'hEE, 8'hEE, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_race", {31'h0, overflow}, 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'h0, overflow}, 32'h0);
        drain_check("fill_drain");
        // Entries sum to 2*i + 0x20 each for i = 1..4
        check("fill_cks", {16'h0, checksum}, 32'h0094);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) capture(8'(8'h20 + i), 8'(8'h40 + i), 8'h60, 1'b1);
        exp_e = exp_q[0];
        check("fp_head0", {8'h0, rd_data}, {8'h0, exp_e});
        rd_ready = 1'b1;
        void'(exp_q.pop_front());
        capture(8'hAA, 8'hBB, 8'h11, 1'b1);
        rd_ready = 1'b0;
        check("fp_count", {29'h0, fifo_count}, 32'h4);
        check("fp_ovf", {31'h0, overflow}, 32'h0);
        drain_check("fp_drain");

        // Checksum with 16- and 8-bit widths, then empty with ready high
        do_reset();
        capture(8'hFF, 8'hFF, 8'h00, 1'b1);
        capture(8'h01, 8'h02, 8'h03, 1'b1);
        rd_ready = 1'b1;
        tick();
        check("cks_pop1", {16'h0, checksum}, 32'h01FE);
        check("cks8_pop1", {24'h0, checksum8}, 32'hFE);
        tick();
        check("cks_pop2", {16'h0, checksum}, 32'h0204);
        check("cks8_pop2", {24'h0, checksum8}, 32'h04);
        tick();
        check("empty_rdy_cks", {16'h0, checksum}, 32'h0204);
        check("empty_rdy_count", {29'h0, fifo_count}, 32'h0);
        rd_ready = 1'b0;
        exp_q.delete();

        // IRQ pending bits
        do_reset();
        irq_mask = 4'b0001;
        irq_in = 4'b0001;
        tick();
        check("irq_edge_pend", {28'h0, irq_pending}, 32'h1);
        check("irq_edge_out", {31'h0, irq_out}, 32'h1);
        tick();
        tick();
        check("irq_held_pend", {28'h0, irq_pending}, 32'h1);
        irq_clr = 4'b0001;
        tick();
        irq_clr = 4'b0000;
        check("irq_clr_pend", {28'h0, irq_pending}, 32'h0);
        check("irq_clr_out", {31'h0, irq_out}, 32'h0);
        tick();
        check("irq_level_pend", {28'h0, irq_pending}, 32'h0);
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0001;
        tick();
        check("irq_rerise_pend", {28'h0, irq_pending}, 32'h1);
        irq_mask = 4'b0000;
        #1;
        check("irq_mask_out", {31'h0, irq_out}, 32'h0);
        // Edge on line 1 coincides with its clear: the edge wins
        irq_in = 4'b0011;
        irq_clr = 4'b0010;
        tick();
        irq_clr = 4'b0000;
        check("irq_race_pend", {28'h0, irq_pending}, 32'h3);
        irq_mask = 4'b0010;
        #1;
        check("irq_mask1_out", {31'h0, irq_out}, 32'h1);

        // Asynchronous reset in the middle of a drain
        do_reset();
        for (int i = 0; i < 4; i++) capture(8'(8'h50 + i), 8'h01, 8'h02, 1'b1);
        irq_mask = 4'hF;
        irq_in = 4'hF;
        rd_ready = 1'b1;
        tick();
        check("mid_count", {29'h0, fifo_count}, 32'h3);
        check("mid_pend", {28'h0, irq_pending}, 32'hF);
        #2;
        irq_in = 4'b0100;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, rd_valid}, 32'h0);
        check("arst_data", {8'h0, rd_data}, 32'h0);
        check("arst_count", {29'h0, fifo_count}, 32'h0);
        check("arst_ovf", {31'h0, overflow}, 32'h0);
        check("arst_cks", {16'h0, checksum}, 32'h0);
        check("arst_pend", {28'h0, irq_pending}, 32'h0);
        check("arst_irq", {31'h0, irq_out}, 32'h0);
        rd_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        // A line already high when reset releases registers one edge
        tick();
        check("post_rst_pend", {28'h0, irq_pending}, 32'h4);
        tick();
        check("post_rst_hold", {28'h0, irq_pending}, 32'h4);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
